// File: rtl/snd_dma_pkg.sv
// Shared types and constants for the multi-channel sound DMA controller.
// Holds the channel state encoding and the index-width helper.
package snd_dma_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ch_state_t;

    localparam int AW_DEF    = 21;
    localparam int DEPTH_DEF = 4;

    // ceil(log2(n)), never less than 1
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/snd_dma_chan.sv
// One sound DMA channel: frame counter, request pending counter,
// IDLE/RUN state machine, end-of-frame interrupt and stop pulse.
module snd_dma_chan
    import snd_dma_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          clk32,
    input  logic          por,
    input  logic          slot_en,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] end_addr,
    input  logic          ch_on,
    input  logic          ch_rep,
    input  logic          sreq,
    input  logic          int_ack,
    input  logic          grant,
    output logic          eligible,
    output logic [AW-1:0] cnt,
    output logic          sframe,
    output logic          stoff,
    output logic          sint
);

    localparam int PW = clog2_min1(DEPTH + 1);
    localparam logic [PW-1:0] PMAX = PW'(DEPTH);

    ch_state_t     state;
    ch_state_t     state_nxt;
    logic [PW-1:0] pend;
    logic [PW-1:0] pend_nxt;
    logic [AW-1:0] cnt_nxt;
    logic [AW-1:0] cnt_inc;
    logic          frame_end;
    logic          stoff_nxt;
    logic          sint_set;
    logic          pend_clr;
    logic          req_ok;

    assign cnt_inc   = cnt + AW'(1);
    assign frame_end = (cnt_inc == end_addr);
    assign sframe    = (state == RUN);
    assign eligible  = (state == RUN) && ch_on && (pend != '0);
    assign req_ok    = sreq && (state == RUN);

    // State register
    always_ff @(posedge clk32 or posedge por) begin
        if (por) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decision, only moves on a memory slot
    always_comb begin
        state_nxt = state;
        if (slot_en) begin
            case (state)
                IDLE: begin
                    if (ch_on && (start_addr != end_addr)) begin
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (!ch_on) begin
                        state_nxt = IDLE;
                    end else if (grant && frame_end && !ch_rep) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Per-slot actions: counter load/advance, stop pulse, irq set
    always_comb begin
        cnt_nxt   = cnt;
        stoff_nxt = 1'b0;
        sint_set  = 1'b0;
        pend_clr  = 1'b0;
        if (slot_en) begin
            case (state)
                IDLE: begin
                    if (ch_on) begin
                        cnt_nxt = start_addr;
                        if (start_addr == end_addr) begin
                            stoff_nxt = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!ch_on) begin
                        pend_clr = 1'b1;
                    end else if (grant) begin
                        cnt_nxt  = cnt_inc;
                        sint_set = frame_end;
                        if (frame_end && ch_rep) begin
                            cnt_nxt = start_addr;
                        end
                        if (frame_end && !ch_rep) begin
                            stoff_nxt = 1'b1;
                            pend_clr  = 1'b1;
                        end
                    end
                end
                default: pend_clr = 1'b1;
            endcase
        end
    end

    // Outstanding request count; a request and a grant together cancel
    always_comb begin
        pend_nxt = pend;
        if (pend_clr) begin
            pend_nxt = '0;
        end else if (req_ok && !grant) begin
            if (pend != PMAX) begin
                pend_nxt = pend + PW'(1);
            end
        end else if (!req_ok && grant) begin
            pend_nxt = pend - PW'(1);
        end
    end

    // Datapath registers and interrupt latch (set beats ack)
    always_ff @(posedge clk32 or posedge por) begin
        if (por) begin
            cnt   <= '0;
            pend  <= '0;
            stoff <= 1'b0;
            sint  <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            pend  <= pend_nxt;
            stoff <= stoff_nxt;
            if (sint_set) begin
                sint <= 1'b1;
            end else if (int_ack) begin
                sint <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/snd_dma_ctrl.sv
// Multi-channel sound DMA frame controller: per-channel engines,
// round-robin slot arbiter and registered fetch strobe/address/channel.
module snd_dma_ctrl
    import snd_dma_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int AW    = AW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CHW   = 1
) (
    input  logic              clk32,
    input  logic              por,
    input  logic              slot_en,
    input  logic [NCH*AW-1:0] start_addr,
    input  logic [NCH*AW-1:0] end_addr,
    input  logic [NCH-1:0]    ch_on,
    input  logic [NCH-1:0]    ch_rep,
    input  logic [NCH-1:0]    sreq,
    input  logic [NCH-1:0]    int_ack,
    output logic              snd_cyc,
    output logic [AW-1:0]     snd_addr,
    output logic [CHW-1:0]    snd_ch,
    output logic [NCH*AW-1:0] cur_addr,
    output logic [NCH-1:0]    sframe,
    output logic [NCH-1:0]    stoff,
    output logic [NCH-1:0]    sint
);

    logic [NCH-1:0] eligible;
    logic [NCH-1:0] grant;
    logic [AW-1:0]  cnt [NCH];
    logic [CHW-1:0] last_grant;
    logic [CHW-1:0] sel;
    logic           found;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        snd_dma_chan #(
            .AW    (AW),
            .DEPTH (DEPTH)
        ) u_chan (
            .clk32      (clk32),
            .por        (por),
            .slot_en    (slot_en),
            .start_addr (start_addr[g*AW +: AW]),
            .end_addr   (end_addr[g*AW +: AW]),
            .ch_on      (ch_on[g]),
            .ch_rep     (ch_rep[g]),
            .sreq       (sreq[g]),
            .int_ack    (int_ack[g]),
            .grant      (grant[g]),
            .eligible   (eligible[g]),
            .cnt        (cnt[g]),
            .sframe     (sframe[g]),
            .stoff      (stoff[g]),
            .sint       (sint[g])
        );
        assign cur_addr[g*AW +: AW] = cnt[g];
    end

    // Round-robin pick: channels after last_grant first, then wrap
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int c = 0; c < NCH; c++) begin
            if (!found && (c > int'(last_grant)) && eligible[c]) begin
                found = 1'b1;
                sel   = CHW'(c);
            end
        end
        for (int c = 0; c < NCH; c++) begin
            if (!found && (c <= int'(last_grant)) && eligible[c]) begin
                found = 1'b1;
                sel   = CHW'(c);
            end
        end
    end

    // One-hot grant, only on a slot
    always_comb begin
        grant = '0;
        if (slot_en && found) begin
            grant = NCH'(1) << sel;
        end
    end

    // Registered fetch outputs and round-robin pointer
    always_ff @(posedge clk32 or posedge por) begin
        if (por) begin
            last_grant <= '0;
            snd_cyc    <= 1'b0;
            snd_addr   <= '0;
            snd_ch     <= '0;
        end else begin
            snd_cyc <= slot_en && found;
            if (slot_en && found) begin
                last_grant <= sel;
                snd_addr   <= cnt[sel];
                snd_ch     <= sel;
            end else begin
                snd_addr <= '0;
                snd_ch   <= '0;
            end
        end
    end

endmodule
